// File: rtl/csi2_frame_controller.sv
// csi2_frame_controller: CSI-2 frame/line sequencer with per-VC payload forwarding and lane reset control.
// Optional build macro CSI2_FRAME_NUMBER_CHECK_EN enables FS frame-number continuity checking.
module csi2_frame_controller #(
    parameter int NUM_LANES      = 2,
    parameter int LINE_WIDTH     = 12,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  header_valid,
    input  logic [1:0]            header_vc,
    input  logic [5:0]            header_data_type,
    input  logic [15:0]           header_word_count,
    input  logic                  header_ecc_ok,
    input  logic                  payload_valid,
    input  logic [31:0]           payload_data,
    input  logic [1:0]            vc_select,
    input  logic                  clear_errors,
    output logic [NUM_LANES-1:0]  lane_reset,
    output logic                  frame_active,
    output logic                  line_active,
    output logic [31:0]           pixel_data,
    output logic                  pixel_valid,
    output logic                  pixel_last,
    output logic [15:0]           frame_number,
    output logic [LINE_WIDTH-1:0] line_count,
    output logic                  frame_done,
    output logic                  error_ecc,
    output logic                  error_sequence,
    output logic                  error_timeout
);
    typedef enum logic [1:0] {IDLE, FRAME, LINE, DRAIN} state_t;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d, base, cur;
    logic                  frame_active_q, frame_active_d, line_active_q, line_active_d;
    logic [31:0]           pixel_data_q, pixel_data_d;
    logic                  pixel_valid_q, pixel_valid_d, pixel_last_q, pixel_last_d;
    logic [15:0]           frame_number_q, frame_number_d;
    logic [LINE_WIDTH-1:0] line_count_q, line_count_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_ecc_q, err_ecc_d, err_seq_q, err_seq_d, err_to_q, err_to_d;
    logic [14:0]           words_q, words_d, words_hdr;
    logic [TW-1:0]         timer_q, timer_d;
    logic [3:0]            rst_cnt_q, rst_cnt_d;
    logic                  busy, pay, is_long, lr_trig, set_ecc, set_seq, set_to;
`ifdef CSI2_FRAME_NUMBER_CHECK_EN
    logic                  fn_seen_q, fn_seen_d;
    logic [15:0]           fn_next;
    assign fn_next = (frame_number_q == 16'hFFFF) ? 16'h0001 : frame_number_q + 16'h0001;
`endif

    assign busy      = (state_q == LINE) || (state_q == DRAIN);
    assign base      = frame_active_q ? FRAME : IDLE;
    assign pay       = payload_valid && (rst_cnt_q == 4'd0);
    assign is_long   = header_data_type >= 6'h10;
    assign words_hdr = 15'(({1'b0, header_word_count} + 17'd3) >> 2);

    always_comb begin
        state_d        = state_q;
        cur            = busy ? base : state_q;
        frame_active_d = frame_active_q;
        line_active_d  = line_active_q;
        pixel_data_d   = pixel_data_q;
        pixel_valid_d  = 1'b0;
        pixel_last_d   = 1'b0;
        frame_number_d = frame_number_q;
        line_count_d   = line_count_q;
        frame_done_d   = 1'b0;
        words_d        = words_q;
        timer_d        = timer_q;
        lr_trig        = 1'b0;
        set_ecc        = 1'b0;
        set_seq        = 1'b0;
        set_to         = 1'b0;
`ifdef CSI2_FRAME_NUMBER_CHECK_EN
        fn_seen_d      = fn_seen_q;
`endif
        if (header_valid) begin
            // A header arriving mid-packet aborts it; the header is then handled from the resting state.
            state_d       = cur;
            line_active_d = 1'b0;
            set_seq       = busy && header_ecc_ok;
            if (!header_ecc_ok) begin
                set_ecc = 1'b1;
                lr_trig = 1'b1;
            end else if (header_vc != vc_select) begin
                if (is_long && header_word_count != 16'd0) begin
                    state_d = DRAIN;
                    words_d = words_hdr;
                    timer_d = '0;
                end else begin
                    lr_trig = 1'b1;
                end
            end else if (!is_long) begin
                lr_trig = 1'b1;
                if (header_data_type == 6'h00) begin
                    if (cur == FRAME) set_seq = 1'b1;
`ifdef CSI2_FRAME_NUMBER_CHECK_EN
                    if (fn_seen_q && header_word_count != 16'd0 && header_word_count != fn_next) set_seq = 1'b1;
                    fn_seen_d = 1'b1;
`endif
                    frame_number_d = header_word_count;
                    line_count_d   = '0;
                    frame_active_d = 1'b1;
                    state_d        = FRAME;
                end else if (header_data_type == 6'h01) begin
                    if (cur == FRAME) begin
                        frame_active_d = 1'b0;
                        frame_done_d   = 1'b1;
                        state_d        = IDLE;
                    end else begin
                        set_seq = 1'b1;
                    end
                end
            end else if (header_word_count == 16'd0) begin
                lr_trig = 1'b1;
            end else begin
                words_d = words_hdr;
                timer_d = '0;
                if (cur == FRAME) begin
                    state_d       = LINE;
                    line_active_d = 1'b1;
                end else begin
                    set_seq = 1'b1;
                    state_d = DRAIN;
                end
            end
        end else if (busy) begin
            if (pay) begin
                words_d = words_q - 15'd1;
                timer_d = '0;
                if (state_q == LINE) begin
                    pixel_data_d  = payload_data;
                    pixel_valid_d = 1'b1;
                end
                if (words_q == 15'd1) begin
                    lr_trig       = 1'b1;
                    state_d       = base;
                    line_active_d = 1'b0;
                    if (state_q == LINE) begin
                        pixel_last_d = 1'b1;
                        line_count_d = (&line_count_q) ? line_count_q : line_count_q + 1'b1;
                    end
                end
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                set_to        = 1'b1;
                lr_trig       = 1'b1;
                state_d       = base;
                line_active_d = 1'b0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
        rst_cnt_d = lr_trig ? 4'(RESET_CYCLES) : (rst_cnt_q != 4'd0) ? rst_cnt_q - 4'd1 : 4'd0;
        err_ecc_d = (err_ecc_q & ~clear_errors) | set_ecc;
        err_seq_d = (err_seq_q & ~clear_errors) | set_seq;
        err_to_d  = (err_to_q & ~clear_errors) | set_to;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            frame_active_q <= 1'b0;
            line_active_q  <= 1'b0;
            pixel_data_q   <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_last_q   <= 1'b0;
            frame_number_q <= '0;
            line_count_q   <= '0;
            frame_done_q   <= 1'b0;
            err_ecc_q      <= 1'b0;
            err_seq_q      <= 1'b0;
            err_to_q       <= 1'b0;
            words_q        <= '0;
            timer_q        <= '0;
            rst_cnt_q      <= '0;
`ifdef CSI2_FRAME_NUMBER_CHECK_EN
            fn_seen_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            frame_active_q <= frame_active_d;
            line_active_q  <= line_active_d;
            pixel_data_q   <= pixel_data_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_last_q   <= pixel_last_d;
            frame_number_q <= frame_number_d;
            line_count_q   <= line_count_d;
            frame_done_q   <= frame_done_d;
            err_ecc_q      <= err_ecc_d;
            err_seq_q      <= err_seq_d;
            err_to_q       <= err_to_d;
            words_q        <= words_d;
            timer_q        <= timer_d;
            rst_cnt_q      <= rst_cnt_d;
`ifdef CSI2_FRAME_NUMBER_CHECK_EN
            fn_seen_q      <= fn_seen_d;
`endif
        end
    end

    assign lane_reset     = {NUM_LANES{rst_cnt_q != 4'd0}};
    assign frame_active   = frame_active_q;
    assign line_active    = line_active_q;
    assign pixel_data     = pixel_data_q;
    assign pixel_valid    = pixel_valid_q;
    assign pixel_last     = pixel_last_q;
    assign frame_number   = frame_number_q;
    assign line_count     = line_count_q;
    assign frame_done     = frame_done_q;
    assign error_ecc      = err_ecc_q;
    assign error_sequence = err_seq_q;
    assign error_timeout  = err_to_q;
endmodule

// File: tb/tb_csi2_frame_controller.sv
// tb_csi2_frame_controller: directed self-checking bench for csi2_frame_controller.
module tb_csi2_frame_controller;
    localparam int TO = 20;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        header_valid = 1'b0, header_ecc_ok = 1'b1;
    logic [1:0]  header_vc = '0, vc_select = '0;
    logic [5:0]  header_data_type = '0;
    logic [15:0] header_word_count = '0;
    logic        payload_valid = 1'b0, clear_errors = 1'b0;
    logic [31:0] payload_data = '0;
    logic [1:0]  lane_reset;
    logic        frame_active, line_active, pixel_valid, pixel_last, frame_done;
    logic        error_ecc, error_sequence, error_timeout;
    logic [31:0] pixel_data;
    logic [15:0] frame_number;
    logic [11:0] line_count;
    int          checks = 0, errors = 0;

    csi2_frame_controller #(.NUM_LANES(2), .LINE_WIDTH(12), .RESET_CYCLES(4), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_n(reset_n), .header_valid(header_valid), .header_vc(header_vc),
        .header_data_type(header_data_type), .header_word_count(header_word_count),
        .header_ecc_ok(header_ecc_ok), .payload_valid(payload_valid), .payload_data(payload_data),
        .vc_select(vc_select), .clear_errors(clear_errors), .lane_reset(lane_reset),
        .frame_active(frame_active), .line_active(line_active), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .pixel_last(pixel_last), .frame_number(frame_number),
        .line_count(line_count), .frame_done(frame_done), .error_ecc(error_ecc),
        .error_sequence(error_sequence), .error_timeout(error_timeout));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc, input logic ecc);
        header_vc = vc; header_data_type = dt; header_word_count = wc; header_ecc_ok = ecc;
        header_valid = 1'b1;
        step();
        header_valid = 1'b0; header_ecc_ok = 1'b1;
    endtask

    task automatic word(input logic [31:0] d);
        payload_valid = 1'b1; payload_data = d;
        step();
        payload_valid = 1'b0;
    endtask

    task automatic lr_len(input string tag);
        int n = 0;
        while (lane_reset != 2'b00 && n < 20) begin
            n++;
            step();
        end
        check(tag, 32'(n), 32'd4);
    endtask

    task automatic clr();
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) step();
        check("rst_lane_reset", 32'(lane_reset), 32'd0);
        check("rst_frame_active", 32'(frame_active), 32'd0);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_frame_number", 32'(frame_number), 32'd0);
        check("rst_errors", 32'({error_ecc, error_sequence, error_timeout}), 32'd0);
        reset_n = 1'b1;
        step();
        // Normal frame with one two-word line
        hdr(2'd0, 6'h00, 16'd5, 1'b1);
        check("fs_active", 32'(frame_active), 32'd1);
        check("fs_number", 32'(frame_number), 32'd5);
        check("fs_lr_on", 32'(lane_reset), 32'd3);
        lr_len("fs_lr_len");
        hdr(2'd0, 6'h2A, 16'd8, 1'b1);
        check("ls_line_active", 32'(line_active), 32'd1);
        check("ls_no_lr", 32'(lane_reset), 32'd0);
        word(32'h11223344);
        check("w1_valid", 32'(pixel_valid), 32'd1);
        check("w1_data", pixel_data, 32'h11223344);
        check("w1_last", 32'(pixel_last), 32'd0);
        word(32'h55667788);
        check("w2_valid", 32'(pixel_valid), 32'd1);
        check("w2_data", pixel_data, 32'h55667788);
        check("w2_last", 32'(pixel_last), 32'd1);
        check("w2_line_count", 32'(line_count), 32'd1);
        check("w2_line_active", 32'(line_active), 32'd0);
        lr_len("eol_lr_len");
        hdr(2'd0, 6'h01, 16'd5, 1'b1);
        check("fe_done", 32'(frame_done), 32'd1);
        check("fe_active", 32'(frame_active), 32'd0);
        lr_len("fe_lr_len");
        check("fe_done_pulse", 32'(frame_done), 32'd0);
        check("fe_number_kept", 32'(frame_number), 32'd5);
        check("t1_no_errors", 32'({error_ecc, error_sequence, error_timeout}), 32'd0);
        // Other-VC long packet is drained without forwarding
        hdr(2'd0, 6'h00, 16'd6, 1'b1);
        lr_len("fs2_lr_len");
        vc_select = 2'd1;
        hdr(2'd0, 6'h2A, 16'd6, 1'b1);
        check("drain_no_line", 32'(line_active), 32'd0);
        word(32'hAAAA0001);
        check("drain_w1_fwd", 32'(pixel_valid), 32'd0);
        check("drain_w1_no_lr", 32'(lane_reset), 32'd0);
        word(32'hAAAA0002);
        check("drain_w2_fwd", 32'(pixel_valid), 32'd0);
        check("drain_lr_on", 32'(lane_reset), 32'd3);
        lr_len("drain_lr_len");
        vc_select = 2'd0;
        check("drain_frame", 32'(frame_active), 32'd1);
        check("drain_no_seq", 32'(error_sequence), 32'd0);
        // ECC error in FRAME
        hdr(2'd0, 6'h12, 16'd4, 1'b0);
        check("ecc_flag", 32'(error_ecc), 32'd1);
        check("ecc_no_line", 32'(line_active), 32'd0);
        check("ecc_frame", 32'(frame_active), 32'd1);
        lr_len("ecc_lr_len");
        clr();
        check("ecc_clear", 32'(error_ecc), 32'd0);
        // One complete line, then a stalled line that times out
        hdr(2'd0, 6'h2A, 16'd4, 1'b1);
        word(32'hC0DE0001);
        check("short_line_last", 32'(pixel_last), 32'd1);
        check("short_line_count", 32'(line_count), 32'd1);
        lr_len("short_line_lr");
        hdr(2'd0, 6'h2A, 16'd12, 1'b1);
        word(32'hC0DE0002);
        check("to_w1_last", 32'(pixel_last), 32'd0);
        n = 0;
        while (!error_timeout && n < TO + 5) begin
            step();
            n++;
        end
        check("to_cycles", 32'(n), 32'(TO));
        check("to_flag", 32'(error_timeout), 32'd1);
        check("to_line_count", 32'(line_count), 32'd1);
        check("to_line_active", 32'(line_active), 32'd0);
        check("to_frame", 32'(frame_active), 32'd1);
        lr_len("to_lr_len");
        clr();
        check("to_clear", 32'(error_timeout), 32'd0);
        // FS during a line aborts it and restarts the frame
        hdr(2'd0, 6'h2A, 16'd8, 1'b1);
        word(32'hBEEF0001);
        hdr(2'd0, 6'h00, 16'd7, 1'b1);
        check("abort_seq", 32'(error_sequence), 32'd1);
        check("abort_last", 32'(pixel_last), 32'd0);
        check("abort_line_count", 32'(line_count), 32'd0);
        check("abort_frame_number", 32'(frame_number), 32'd7);
        check("abort_line_active", 32'(line_active), 32'd0);
        lr_len("abort_lr_len");
        clr();
        check("seq_clear", 32'(error_sequence), 32'd0);
        // FE in IDLE with a simultaneous clear: the set wins
        hdr(2'd0, 6'h01, 16'd7, 1'b1);
        check("fe2_done", 32'(frame_done), 32'd1);
        lr_len("fe2_lr_len");
        clear_errors = 1'b1;
        hdr(2'd0, 6'h01, 16'd7, 1'b1);
        clear_errors = 1'b0;
        check("fe_idle_seq", 32'(error_sequence), 32'd1);
        check("fe_idle_no_done", 32'(frame_done), 32'd0);
        lr_len("fe_idle_lr_len");
        clr();
`ifdef CSI2_FRAME_NUMBER_CHECK_EN
        hdr(2'd0, 6'h00, 16'hFFFF, 1'b1);
        lr_len("fn_a_lr");
        hdr(2'd0, 6'h01, 16'hFFFF, 1'b1);
        lr_len("fn_b_lr");
        clr();
        hdr(2'd0, 6'h00, 16'h0001, 1'b1);
        check("fn_wrap_ok", 32'(error_sequence), 32'd0);
        lr_len("fn_c_lr");
        hdr(2'd0, 6'h01, 16'h0001, 1'b1);
        lr_len("fn_d_lr");
        hdr(2'd0, 6'h00, 16'h0003, 1'b1);
        check("fn_skip_err", 32'(error_sequence), 32'd1);
        lr_len("fn_e_lr");
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
